fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side drain stage directly downstream of the synchronous FIFO.
- Drives the FIFO read port (rd_en, with data_out one cycle later) and converts it into a valid/ready output stream with burst framing (last every BURST_LEN beats).
- Hides the FIFO's one-cycle read latency with a small credit-based buffer, so throughput is full with no combinational path from m_ready to fifo_rd_en.
- Flags any FIFO underflow as a sticky error.

Parameters:
FIFO_WIDTH, Shared_pkg::FIFO_WIDTH (16), data width; matches the FIFO data_out.
BUF_DEPTH, 3, output buffer entries; legal values are 3 or more (3 is the minimum for full throughput).
BURST_LEN, Shared_pkg::BURST_LEN (8), beats per burst; legal values are 1 or more.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
fifo_data_out  input  FIFO_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
fifo_empty  input  1  FIFO empty flag.
fifo_underflow  input  1  FIFO underflow flag.
fifo_rd_en  output  1  FIFO read request.
m_data  output  FIFO_WIDTH  stream data (buffer head).
m_valid  output  1  stream valid.
m_ready  input  1  downstream ready.
m_last  output  1  final beat of the current burst.
err_underflow  output  1  sticky underflow error.
clr_err  input  1  synchronous clear of err_underflow.

Behaviour:
- Reset: clock is clk; reset is rst, asynchronous and active-high.
  - While rst=1: buffer count=0, in-flight flag=0, beat_cnt=0, err_underflow=0.
  - While rst=1: m_valid=0, m_last=0, m_data=0, fifo_rd_en=0 (combinational output is gated by rst).
- Read issue:
  - fifo_rd_en = !rst && !fifo_empty && (count + inflight_q) < BUF_DEPTH.
  - Only registered state is used; m_ready never affects fifo_rd_en in the same cycle.
  - inflight_q <= fifo_rd_en on every clk edge.
- Capture: when inflight_q=1, fifo_data_out is written to the buffer tail in that cycle. The credit rule guarantees no buffer overflow.
- Output:
  - m_valid = (count != 0); m_data = head entry.
  - Pop on m_valid && m_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Without m_ready, m_data and m_last hold stable.
- Latency: first word appears on m_valid 2 cycles after fifo_empty falls (rd_en cycle, capture cycle). Steady state is 1 beat per cycle.
- Framing:
  - beat_cnt (width max(1, $clog2(BURST_LEN))) increments on each accepted beat.
  - beat_cnt wraps to 0 on the accepted beat where m_last=1.
  - m_last = m_valid && (beat_cnt == BURST_LEN-1). For BURST_LEN=1, m_last = m_valid.
  - beat_cnt is not affected by stalls or by a drained FIFO.
- Error:
  - fifo_underflow=1 at a clk edge sets err_underflow.
  - clr_err clears it; set wins over a simultaneous clr_err.
  - A correct fifo_rd_en never causes underflow, so any underflow means a protocol breach.
- Boundaries:
  - Buffer full with m_ready=0: fifo_rd_en=0, and the FIFO is free to go full and overflow upstream.
  - FIFO empty: no read is issued, and m_valid drops once the buffer drains.
  - Mid-operation reset: buffered and in-flight words are discarded and the burst count restarts at 0. The FIFO's own reset is handled at system level.

Decomposition:
- Shared_pkg gains localparam BURST_LEN and a typedef of logic [FIFO_WIDTH-1:0] as data_t; the block imports Shared_pkg::*.
- Sub-module stream_skid_buf: BUF_DEPTH-entry circular buffer with push, pop, count, head.
- The top level holds read issue, the in-flight flag, the beat counter and the error flag.
- A FIFO_RD_IF interface with DUT, TB and MON modports and a data_sampled event is used for the bench.

Test Plan:
- Reset: rst=1 with FIFO non-empty -> fifo_rd_en=0, m_valid=0, m_last=0, err_underflow=0. rst falling -> fifo_rd_en=1 on the next evaluation.
- Streaming: FIFO preloaded with 0x0001..0x0010, m_ready=1 -> first m_valid 2 cycles after rst release, then 16 consecutive beats in order; m_last on 0x0008 and 0x0010.
- Backpressure: FIFO holds 10 words, m_ready=0 for 20 cycles -> exactly 3 fifo_rd_en pulses, m_data=0x0001 held stable. Release m_ready -> remaining words in order, no loss or duplicate.
- Bubbles and wrap: FIFO fed 1 word every 3 cycles, m_ready=1 -> m_valid toggles; m_last on the 8th and 16th accepted beat regardless of gaps.
- Error: force fifo_underflow=1 for 1 cycle -> err_underflow=1 and held. clr_err with a second fifo_underflow in the same cycle -> stays 1. clr_err alone -> 0.
- Reset mid-burst: after 5 accepted beats with 2 words buffered, pulse rst asynchronously -> m_valid=0 immediately. After release, the next accepted beat is counted as beat 0 (m_last on the 8th).

Source files
------------

// File: rtl/Shared_pkg.sv
// Shared definitions for the FIFO slice: data width, burst framing length,
// the data word type and a counter-width helper.
package Shared_pkg;

   localparam int FIFO_WIDTH = 16;
   localparam int BURST_LEN  = 8;

   typedef logic [FIFO_WIDTH-1:0] data_t;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/FIFO_RD_IF.sv
// Signal bundle of the FIFO read side and the output stream, with an event
// that marks each point where the stream is sampled.
interface FIFO_RD_IF #(
   parameter int W = Shared_pkg::FIFO_WIDTH
) (
   input logic clk
);

   logic [W-1:0] fifo_data_out;
   logic         fifo_empty;
   logic         fifo_underflow;
   logic         fifo_rd_en;
   logic [W-1:0] m_data;
   logic         m_valid;
   logic         m_ready;
   logic         m_last;
   logic         err_underflow;
   logic         clr_err;

   event data_sampled;

   modport DUT (
      input  clk, fifo_data_out, fifo_empty, fifo_underflow, m_ready, clr_err,
      output fifo_rd_en, m_data, m_valid, m_last, err_underflow
   );

   modport TB (
      input  clk, fifo_rd_en, m_data, m_valid, m_last, err_underflow,
      output fifo_data_out, fifo_empty, fifo_underflow, m_ready, clr_err
   );

   modport MON (
      input clk, fifo_data_out, fifo_empty, fifo_underflow, fifo_rd_en,
            m_data, m_valid, m_ready, m_last, err_underflow, clr_err
   );

endinterface

// File: rtl/stream_skid_buf.sv
// Small circular buffer between the FIFO read port and the output stream.
// Overflow is prevented upstream by the credit rule, underflow by m_valid.
module stream_skid_buf
   import Shared_pkg::*;
#(
   parameter  int WIDTH = FIFO_WIDTH,
   parameter  int DEPTH = 3,
   localparam int PTR_W = cnt_width(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Storage write at the tail.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (push) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Head/tail pointers advance independently on pop/push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (push) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
      end
   end

   // Occupancy; simultaneous push and pop leave it unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: issues FIFO reads against buffer credit, presents the
// words as a valid/ready stream with burst framing, and latches underflow.
module fifo_rd_stream #(
   parameter int FIFO_WIDTH = Shared_pkg::FIFO_WIDTH,
   parameter int BUF_DEPTH  = 3,
   parameter int BURST_LEN  = Shared_pkg::BURST_LEN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FIFO_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic [FIFO_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  err_underflow,
   input  logic                  clr_err
);

   import Shared_pkg::*;

   localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
   localparam int BEAT_W = cnt_width(BURST_LEN);

   logic                  inflight_r;
   logic [BEAT_W-1:0]     beat_cnt_r;
   logic                  err_r;

   logic [CNT_W-1:0]      count_s;
   logic [FIFO_WIDTH-1:0] head_s;
   logic [CNT_W:0]        credit_used_s;
   logic                  rd_en_s;
   logic                  valid_s;
   logic                  last_s;
   logic                  accept_s;

   stream_skid_buf #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_r),
      .push_data (fifo_data_out),
      .pop       (accept_s),
      .head      (head_s),
      .count     (count_s)
   );

   // Read issue from registered state only: buffered plus in-flight words
   // must stay below the buffer depth, so m_ready never reaches fifo_rd_en.
   always_comb begin
      credit_used_s = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r};
      rd_en_s       = !rst && !fifo_empty
                      && (credit_used_s < (CNT_W + 1)'(BUF_DEPTH));
      valid_s       = !rst && (count_s != {CNT_W{1'b0}});
      last_s        = valid_s && (beat_cnt_r == BEAT_W'(BURST_LEN - 1));
      accept_s      = valid_s && m_ready;
   end

   // Output drive, forced to zero while reset is asserted.
   always_comb begin
      fifo_rd_en    = rd_en_s;
      m_valid       = valid_s;
      m_last        = last_s;
      err_underflow = err_r;
      if (rst) begin
         m_data = {FIFO_WIDTH{1'b0}};
      end else begin
         m_data = head_s;
      end
   end

   // A read issued this cycle returns data next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= rd_en_s;
      end
   end

   // Burst beat counter, advanced only by accepted beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt_r <= {BEAT_W{1'b0}};
      end else if (accept_s) begin
         if (last_s) begin
            beat_cnt_r <= {BEAT_W{1'b0}};
         end else begin
            beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
         end
      end else begin
         beat_cnt_r <= beat_cnt_r;
      end
   end

   // Sticky underflow flag; a new underflow wins over a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (fifo_underflow) begin
         err_r <= 1'b1;
      end else if (clr_err) begin
         err_r <= 1'b0;
      end else begin
         err_r <= err_r;
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO model, stream scoreboard,
// error-flag vector table and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_fifo_rd_stream;

   localparam int W     = Shared_pkg::FIFO_WIDTH;
   localparam int DEPTH = 3;
   localparam int BL    = 8;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } exp_t;

   typedef struct {
      logic uf;
      logic clr;
      logic exp_err;
   } err_vec_t;

   logic clk;
   logic rst;

   FIFO_RD_IF #(.W(W)) fif (.clk(clk));

   fifo_rd_stream #(
      .FIFO_WIDTH (W),
      .BUF_DEPTH  (DEPTH),
      .BURST_LEN  (BL)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fifo_data_out  (fif.fifo_data_out),
      .fifo_empty     (fif.fifo_empty),
      .fifo_underflow (fif.fifo_underflow),
      .fifo_rd_en     (fif.fifo_rd_en),
      .m_data         (fif.m_data),
      .m_valid        (fif.m_valid),
      .m_ready        (fif.m_ready),
      .m_last         (fif.m_last),
      .err_underflow  (fif.err_underflow),
      .clr_err        (fif.clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] mem_q[$];
   exp_t         exp_q[$];
   int n_chk     = 0;
   int n_fail    = 0;
   int sb_idx    = 0;
   int rd_pulses = 0;
   int accepts   = 0;
   int valid_hi  = 0;
   int valid_lo  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_push(input logic [W-1:0] d);
      exp_t e;
      e.data = d;
      e.last = ((sb_idx % BL) == (BL - 1));
      sb_idx++;
      exp_q.push_back(e);
   endtask

   task automatic feed(input logic [W-1:0] d);
      mem_q.push_back(d);
      exp_push(d);
      fif.fifo_empty = 1'b0;
   endtask

   // One clock: score the beat at the negedge, then update the FIFO model after the edge.
   task automatic cycle();
      logic rd;
      exp_t e;
      @(negedge clk);
      -> fif.data_sampled;
      rd = fif.fifo_rd_en;
      if (fif.m_valid) valid_hi++; else valid_lo++;
      if (fif.m_valid && fif.m_ready) begin
         accepts++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", fif.m_data);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", 32'(fif.m_data), 32'(e.data));
            chk("beat_last", 32'(fif.m_last), 32'(e.last));
         end
      end
      @(posedge clk);
      #1;
      if (rd) begin
         rd_pulses++;
         if (mem_q.size() > 0) fif.fifo_data_out = mem_q.pop_front();
      end
      fif.fifo_empty = (mem_q.size() == 0);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         cycle();
         n++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   err_vec_t err_tbl[9];

   initial begin
      int n;

      err_tbl[0] = '{1'b1, 1'b0, 1'b1};
      err_tbl[1] = '{1'b0, 1'b0, 1'b1};
      err_tbl[2] = '{1'b1, 1'b1, 1'b1};
      err_tbl[3] = '{1'b0, 1'b0, 1'b1};
      err_tbl[4] = '{1'b0, 1'b1, 1'b0};
      err_tbl[5] = '{1'b0, 1'b0, 1'b0};
      err_tbl[6] = '{1'b0, 1'b1, 1'b0};
      err_tbl[7] = '{1'b1, 1'b0, 1'b1};
      err_tbl[8] = '{1'b0, 1'b1, 1'b0};

      rst                = 1'b1;
      fif.fifo_data_out  = '0;
      fif.fifo_empty     = 1'b1;
      fif.fifo_underflow = 1'b0;
      fif.clr_err        = 1'b0;
      fif.m_ready        = 1'b0;

      // Reset with a non-empty FIFO, then plain streaming of 16 words.
      for (int i = 1; i <= 16; i++) feed(W'(i));
      fif.m_ready = 1'b1;
      repeat (2) cycle();
      chk("rst_rd_en",   32'(fif.fifo_rd_en),    32'd0);
      chk("rst_valid",   32'(fif.m_valid),       32'd0);
      chk("rst_last",    32'(fif.m_last),        32'd0);
      chk("rst_err",     32'(fif.err_underflow), 32'd0);
      chk("rst_data",    32'(fif.m_data),        32'd0);
      rst = 1'b0;
      #1;
      chk("rd_en_after_rst", 32'(fif.fifo_rd_en), 32'd1);
      cycle();
      chk("valid_lat1", 32'(fif.m_valid), 32'd0);
      cycle();
      chk("valid_lat2", 32'(fif.m_valid), 32'd1);
      accepts = 0;
      repeat (16) cycle();
      chk("stream_beats",   32'(accepts),       32'd16);
      chk("stream_drained", 32'(exp_q.size()),  32'd0);
      chk("stream_idle",    32'(fif.m_valid),   32'd0);

      // Error flag vectors.
      foreach (err_tbl[i]) begin
         fif.fifo_underflow = err_tbl[i].uf;
         fif.clr_err        = err_tbl[i].clr;
         cycle();
         chk($sformatf("err_vec%0d", i), 32'(fif.err_underflow), 32'(err_tbl[i].exp_err));
      end
      fif.fifo_underflow = 1'b0;
      fif.clr_err        = 1'b0;

      // Backpressure: 10 words, no ready for 20 cycles.
      fif.m_ready = 1'b0;
      rd_pulses   = 0;
      for (int i = 1; i <= 10; i++) feed(W'(i));
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (i >= 1) begin
            chk("bp_valid", 32'(fif.m_valid), 32'd1);
            chk("bp_head",  32'(fif.m_data),  32'h1);
         end
      end
      chk("bp_rd_pulses",   32'(rd_pulses),      32'd3);
      chk("bp_full_no_rd",  32'(fif.fifo_rd_en), 32'd0);
      fif.m_ready = 1'b1;
      accepts = 0;
      drain("bp_drained", 30);
      chk("bp_beats", 32'(accepts), 32'd10);

      // Bubbles: one word every 3 cycles after a fresh reset.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      sb_idx   = 0;
      valid_hi = 0;
      valid_lo = 0;
      for (int i = 0; i < 16; i++) begin
         feed(W'(16'h0100 + i));
         repeat (3) cycle();
      end
      drain("bubble_drained", 10);
      chk("bubble_valid_hi", 32'(valid_hi > 0), 32'd1);
      chk("bubble_valid_lo", 32'(valid_lo > 0), 32'd1);

      // Reset mid-burst with words buffered and possibly in flight.
      fif.m_ready = 1'b0;
      for (int i = 0; i < 20; i++) feed(W'(16'h0200 + i));
      repeat (4) cycle();
      fif.m_ready = 1'b1;
      accepts = 0;
      n = 0;
      while (accepts < 5 && n < 20) begin
         cycle();
         n++;
      end
      chk("mid_beats", 32'(accepts), 32'd5);
      fif.m_ready = 1'b0;
      cycle();
      chk("mid_valid_before", 32'(fif.m_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(fif.m_valid),    32'd0);
      chk("mid_rst_last",  32'(fif.m_last),     32'd0);
      chk("mid_rst_rd_en", 32'(fif.fifo_rd_en), 32'd0);
      exp_q.delete();
      sb_idx = 0;
      foreach (mem_q[i]) exp_push(mem_q[i]);
      cycle();
      rst = 1'b0;
      fif.m_ready = 1'b1;
      drain("mid_drained", 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
